redmule_tcdm_split: RTL and testbench

Bridges RedMulE's single wide memory request/response channel onto MP independent 32-bit TCDM ports, sitting directly between the RedMulE streamer and the cluster TCDM interconnect. Each port is granted independently rather than all-or-nothing, so skewed grants and skewed responses are handled. Per-port response FIFOs re-align the data into one wide response beat. An outstanding-transaction limit guarantees the FIFOs can never overflow.

---
 rtl/redmule_tcdm_split.sv | 125 ++++++++++++
 tb/tb_redmule_tcdm_split.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tcdm_split.sv
// Splits one wide RedMulE request into MP independently granted 32-bit TCDM requests.
// Per-port response FIFOs re-align the narrow responses into one wide beat, which is never backpressured.
module redmule_tcdm_split #(
    parameter int MP = 4,
    parameter int D  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        add_i,
    input  logic               wen_i,
    input  logic [MP*4-1:0]    be_i,
    input  logic [MP*32-1:0]   data_i,
    output logic [MP*32-1:0]   r_data_o,
    output logic               r_valid_o,
    output logic [MP-1:0]      tcdm_req_o,
    input  logic [MP-1:0]      tcdm_gnt_i,
    output logic [MP*32-1:0]   tcdm_add_o,
    output logic [MP-1:0]      tcdm_wen_o,
    output logic [MP*4-1:0]    tcdm_be_o,
    output logic [MP*32-1:0]   tcdm_data_o,
    input  logic [MP*32-1:0]   tcdm_r_data_i,
    input  logic [MP-1:0]      tcdm_r_valid_i,
    output logic               busy_o,
    output logic               err_o
);

    localparam int CW  = $clog2(D + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (D > 1) ? $clog2(D) : 1;

    logic          sclr;
    logic [MP-1:0] done_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          pop;
    logic          slot_free;
    logic [MP-1:0] not_empty;
    logic [MP-1:0] push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign sclr      = rst_i | clear_i;
    assign pop       = &not_empty;
    assign r_valid_o = pop;

    // A pop retires a transaction this cycle, so its slot can be reused immediately.
    assign slot_free  = (cnt_q < CW'(D)) | pop;
    assign tcdm_req_o = {MP{req_i & slot_free}} & ~done_q;
    assign gnt_o      = req_i & slot_free & (&(done_q | tcdm_gnt_i));

    assign busy_o = req_i | (cnt_q != '0) | (|not_empty);
    assign err_o  = err_q;

    for (genvar ii = 0; ii < MP; ii++) begin : g_port
        logic [31:0]   mem_q [D];
        logic [PW-1:0] wr_ptr_q;
        logic [PW-1:0] rd_ptr_q;
        logic [CW-1:0] occ_q;
        logic [CW-1:0] occ_after;
        logic [CW:0]   limit;

        assign tcdm_add_o[32*ii +: 32]  = add_i + 32'(4 * ii);
        assign tcdm_wen_o[ii]           = wen_i;
        assign tcdm_be_o[4*ii +: 4]     = be_i[4*ii +: 4];
        assign tcdm_data_o[32*ii +: 32] = data_i[32*ii +: 32];

        assign not_empty[ii] = (occ_q != '0);
        assign occ_after     = occ_q - CW'(pop);
        // A port already granted for the wide request still pending owes one response not yet in cnt.
        assign limit         = {1'b0, cnt_q} + CW1'(done_q[ii]);
        assign push[ii]      = tcdm_r_valid_i[ii] & ({1'b0, occ_after} < limit);

        assign r_data_o[32*ii +: 32] = pop ? mem_q[rd_ptr_q] : 32'h0;

        always_ff @(posedge clk_i) begin
            if (push[ii] && !sclr) begin
                mem_q[wr_ptr_q] <= tcdm_r_data_i[32*ii +: 32];
            end
        end

        always_ff @(posedge clk_i) begin
            if (sclr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (push[ii]) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                occ_q <= occ_after + CW'(push[ii]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sclr) begin
            done_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (gnt_o) begin
                done_q <= '0;
            end else begin
                done_q <= done_q | (tcdm_req_o & tcdm_gnt_i);
            end
            if (gnt_o && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !gnt_o) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (|(tcdm_r_valid_i & ~push)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_split.sv
// Randomised and directed bench for redmule_tcdm_split: a TCDM slave model answers narrow
// requests while a wide-level memory model predicts every wide response beat for the monitor.
module tb_redmule_tcdm_split;

    localparam int MP = 4;
    localparam int D  = 2;
    localparam int W  = MP * 32;
    localparam int BW = MP * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_i, clear_i, req_i, gnt_o, wen_i, r_valid_o, busy_o, err_o;
    logic [31:0]   add_i;
    logic [BW-1:0] be_i;
    logic [W-1:0]  data_i, r_data_o, tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
    logic [MP-1:0] tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
    logic [BW-1:0] tcdm_be_o;

    redmule_tcdm_split #(.MP(MP), .D(D)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .data_i(data_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // slave knobs, written by the main sequence only at negedge
    logic          gnt_rand = 1'b0;
    logic          lat_rand = 1'b0;
    logic          resp_hold = 1'b0;
    logic [MP-1:0] gnt_block = '0;
    int            lat [MP];

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    typedef struct {
        logic          rd;
        logic [W-1:0]  dat;
    } exp_t;
    exp_t exp_q [$];

    int            req_cyc, gnt_cyc;
    logic [W-1:0]  gnt_add;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wide-level reference: a granted wide request reads or writes MP consecutive words.
    task automatic push_expect(input logic [31:0] a, input logic w, input logic [BW-1:0] b,
                               input logic [W-1:0] d);
        exp_t        e;
        logic [31:0] addr, word;
        e.rd  = w;
        e.dat = '0;
        for (int ii = 0; ii < MP; ii++) begin
            addr = a + 32'(4 * ii);
            word = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
            if (w) begin
                e.dat[32*ii +: 32] = word;
            end else begin
                for (int bb = 0; bb < 4; bb++)
                    if (b[4*ii+bb]) word[8*bb +: 8] = d[32*ii+8*bb +: 8];
                ref_mem[addr] = word;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [BW-1:0] b,
                         input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b1; add_i = a; wen_i = w; be_i = b; data_i = d;
        req_cyc = cyc;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (gnt_o) begin
                ok      = 1'b1;
                gnt_cyc = cyc;
                gnt_add = tcdm_add_o;
                push_expect(a, w, b, d);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: addr %h never granted", a);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_int(nm, exp_q.size(), 0);
    endtask

    // TCDM slave: in-order responses per port, latency fixed per port or random.
    int          rdue [MP][16];
    logic [31:0] rdat [MP][16];
    int          rh [MP];
    int          rt [MP];
    int          last_due [MP];

    initial begin
        logic [31:0] a, word;
        int          due;
        tcdm_gnt_i = '0;
        tcdm_r_valid_i = '0;
        tcdm_r_data_i = '0;
        for (int ii = 0; ii < MP; ii++) begin
            rh[ii] = 0; rt[ii] = 0; last_due[ii] = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int ii = 0; ii < MP; ii++) begin
                tcdm_gnt_i[ii] = !gnt_block[ii] && (!gnt_rand || $urandom_range(0, 99) < 60);
                if (!resp_hold && rh[ii] != rt[ii] && rdue[ii][rh[ii] % 16] <= cyc) begin
                    tcdm_r_valid_i[ii] = 1'b1;
                    tcdm_r_data_i[32*ii +: 32] = rdat[ii][rh[ii] % 16];
                    rh[ii]++;
                end else begin
                    tcdm_r_valid_i[ii] = 1'b0;
                    tcdm_r_data_i[32*ii +: 32] = $urandom;
                end
            end
            @(negedge clk);
            for (int ii = 0; ii < MP; ii++) begin
                if (tcdm_req_o[ii] && tcdm_gnt_i[ii]) begin
                    a    = tcdm_add_o[32*ii +: 32];
                    word = slave_mem.exists(a) ? slave_mem[a] : mem_init(a);
                    if (!tcdm_wen_o[ii]) begin
                        for (int bb = 0; bb < 4; bb++)
                            if (tcdm_be_o[4*ii+bb]) word[8*bb +: 8] = tcdm_data_o[32*ii+8*bb +: 8];
                        slave_mem[a] = word;
                        word = $urandom;
                    end
                    due = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat[ii]);
                    if (rh[ii] != rt[ii] && due <= last_due[ii]) due = last_due[ii] + 1;
                    last_due[ii] = due;
                    rdue[ii][rt[ii] % 16] = due;
                    rdat[ii][rt[ii] % 16] = word;
                    rt[ii]++;
                end
            end
        end
    end

    // Monitor: every wide response beat must match the oldest expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (r_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid: data %h with no transaction outstanding", r_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd) check("rdata", r_data_o, e.dat);
                    else      check_int("write_beat", int'(r_valid_o), 1);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int            rq_cnt [MP];
        int            g_cnt, g_at, rv_at, blocked, early, rv;
        logic [31:0]   a;
        logic [BW-1:0] bb;
        logic [W-1:0]  dd;

        rst_i = 1'b1; clear_i = 1'b0; req_i = 1'b0;
        add_i = '0; wen_i = 1'b1; be_i = '0; data_i = '0;
        for (int ii = 0; ii < MP; ii++) lat[ii] = 1;
        for (int ii = 0; ii < MP; ii++) begin
            slave_mem[32'h1000 + 32'(4 * ii)] = 32'hA0 + 32'(ii);
            ref_mem[32'h1000 + 32'(4 * ii)]   = 32'hA0 + 32'(ii);
        end

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tcdm_req", W'(tcdm_req_o), '0);
        check_int("rst_gnt", int'(gnt_o), 0);
        check_int("rst_rvalid", int'(r_valid_o), 0);
        check_int("rst_busy", int'(busy_o), 0);
        check_int("rst_err", int'(err_o), 0);
        check("rst_rdata", r_data_o, '0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // aligned burst
        issue(32'h1000, 1'b1, '1, '0);
        check_int("burst_gnt_latency", gnt_cyc - req_cyc, 0);
        check("burst_addr", gnt_add, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
        idle();
        @(negedge clk);
        check_int("burst_rvalid_early", int'(r_valid_o), 0);
        @(negedge clk);
        check_int("burst_rvalid", int'(r_valid_o), 1);
        check("burst_rdata", r_data_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        drain("burst_drain");

        // skewed grants: port 2 held off for three cycles
        gnt_block = 4'b0100;
        @(posedge clk); #1;
        req_i = 1'b1; add_i = 32'h3000; wen_i = 1'b1; be_i = '1; data_i = '0;
        g_cnt = 0; g_at = -1;
        for (int ii = 0; ii < MP; ii++) rq_cnt[ii] = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int ii = 0; ii < MP; ii++) if (tcdm_req_o[ii]) rq_cnt[ii]++;
            if (gnt_o) begin
                g_cnt++;
                g_at = c;
                push_expect(32'h3000, 1'b1, '1, '0);
            end
            if (c == 2) gnt_block = '0;
            @(posedge clk); #1;
            if (g_at >= 0) req_i = 1'b0;
        end
        check_int("skew_req_p0", rq_cnt[0], 1);
        check_int("skew_req_p1", rq_cnt[1], 1);
        check_int("skew_req_p2", rq_cnt[2], 4);
        check_int("skew_req_p3", rq_cnt[3], 1);
        check_int("skew_gnt_count", g_cnt, 1);
        check_int("skew_gnt_cycle", g_at, 3);
        drain("skew_drain");

        // skewed responses: port 0 answers five cycles after the others
        lat[0] = 6;
        issue(32'h1000, 1'b1, '1, '0);
        idle();
        early = 0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n < 7 && r_valid_o) early++;
            if (n == 7) check_int("skewresp_rvalid", int'(r_valid_o), 1);
        end
        check_int("skewresp_no_early", early, 0);
        lat[0] = 1;
        drain("skewresp_drain");

        // address wrap
        issue(32'hFFFF_FFF8, 1'b1, '1, '0);
        check("wrap_addr", gnt_add, {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
        idle();
        drain("wrap_drain");

        // outstanding limit
        resp_hold = 1'b1;
        issue(32'h4000, 1'b1, '1, '0);
        issue(32'h4010, 1'b1, '1, '0);
        @(posedge clk); #1;
        add_i = 32'h4020;
        blocked = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (tcdm_req_o != '0 || gnt_o) blocked++;
        end
        check_int("limit_blocked", blocked, 0);
        check_int("limit_busy", int'(busy_o), 1);
        resp_hold = 1'b0;
        rv_at = -1; g_at = -1;
        for (int n = 0; n < 20 && g_at < 0; n++) begin
            @(negedge clk);
            if (r_valid_o && rv_at < 0) rv_at = cyc;
            if (gnt_o) begin
                g_at = cyc;
                push_expect(32'h4020, 1'b1, '1, '0);
            end
        end
        idle();
        check_int("limit_pop_seen", int'(rv_at >= 0), 1);
        check_int("limit_gnt_on_pop", g_at, rv_at);
        drain("limit_drain");

        // randomised traffic
        gnt_rand = 1'b1;
        lat_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            a  = 32'h2000 + 32'(4 * $urandom_range(0, 15));
            bb = BW'($urandom);
            for (int ii = 0; ii < MP; ii++) dd[32*ii +: 32] = $urandom;
            issue(a, 1'($urandom_range(0, 1)), bb, dd);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end
        idle();
        drain("random_drain");
        check_int("random_busy", int'(busy_o), 0);
        check_int("random_err", int'(err_o), 0);
        gnt_rand = 1'b0;
        lat_rand = 1'b0;

        // reset with one read in flight; its responses must be dropped as spurious
        resp_hold = 1'b1;
        issue(32'h5000, 1'b1, '1, '0);
        idle();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        resp_hold = 1'b0;
        rv = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (r_valid_o) rv++;
        end
        check_int("midrst_no_rvalid", rv, 0);
        check_int("midrst_err", int'(err_o), 1);
        check_int("midrst_busy", int'(busy_o), 0);
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        check_int("clear_err", int'(err_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
